// File: rtl/lutram_fifo_pkg.sv
// Shared sizing constants for the 16-deep distributed-RAM FIFO.
package lutram_fifo_pkg;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
endpackage

// File: rtl/dist_ram_16xw.sv
// 16xWIDTH distributed RAM: synchronous write, asynchronous read, no reset.
// The write lands at the clk edge; a read of that address in the next cycle returns the new word.
module dist_ram_16xw
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lutram_fifo16.sv
// First-word-fall-through FIFO: 16-word distributed RAM plus one output register (17 words).
// Empty-to-valid latency 1 cycle; in_ready drops only when the RAM is full, independent of out_ready.
module lutram_fifo16
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       level,
  output logic             almost_full
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  ram_count;
  logic [WIDTH-1:0]  ram_rdata;
  logic              clear;
  logic              push;
  logic              load;

  assign clear    = rst | flush;
  assign in_ready = (ram_count != CNT_W'(DEPTH)) & ~clear;
  assign push     = in_valid & in_ready;
  // The RAM must already hold a word before the edge, so a load never reads the slot being written.
  assign load     = (ram_count != '0) & (~out_valid | out_ready);

  dist_ram_16xw #(.WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (load) begin
        out_data  <= ram_rdata;
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      ram_count <= ram_count + CNT_W'(push) - CNT_W'(load);
    end
  end

  assign level       = ram_count + {4'b0000, out_valid};
  assign almost_full = (ram_count >= CNT_W'(AFULL_LEVEL));

endmodule

// File: tb/tb_lutram_fifo16.sv
// Directed and backpressure checks of lutram_fifo16 against hand-derived expectations.
module tb_lutram_fifo16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        almost_full;

  int checks = 0;
  int errors = 0;

  lutram_fifo16 #(.WIDTH(16), .AFULL_LEVEL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 37 + 5);
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    in_data = 16'hA5A5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL single_after_push valid %b level %0d want 0 and 1", out_valid, level); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hA5A5) begin errors++; $display("FAIL single_latency valid %b data %h want 1 a5a5", out_valid, out_data); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || level !== 5'd1) begin
        errors++; $display("FAIL single_hold cycle %0d valid %b data %h level %0d want 1 a5a5 1", i, out_valid, out_data, level);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_pop valid %b level %0d want 0 0", out_valid, level); end
  endtask

  task automatic test_fill();
    int ram;
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = 16'(i); in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready word %0d got 0 want 1", i); end
      step();
      ram = (i == 0) ? 1 : i;
      checks++;
      if (almost_full !== (ram >= 12)) begin
        errors++; $display("FAIL fill_almost_full word %0d got %b want %b", i, almost_full, (ram >= 12));
      end
    end
    in_data = 16'hBEEF;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready got %b want 0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (level !== 5'd17) begin errors++; $display("FAIL fill_level got %0d want 17", level); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af_full got %b want 1", almost_full); end
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        errors++; $display("FAIL fill_drain word %0d valid %b data %h want 1 %h", i, out_valid, out_data, 16'(i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL fill_drain_empty valid %b level %0d want 0 0", out_valid, level); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = 16'h0100 + 16'(i); in_valid = 1'b1;
      step();
    end
    in_data = 16'h0077; in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready got %b want 0", in_ready); end
    step();
    out_ready = 1'b0;
    checks++; if (level !== 5'd16 || out_data !== 16'h0101) begin errors++; $display("FAIL fullpop_one_pop level %0d data %h want 16 0101", level, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_reopen got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (level !== 5'd17) begin errors++; $display("FAIL fullpop_push_next level %0d want 17", level); end
    out_ready = 1'b1;
    for (int i = 1; i < 18; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== ((i == 17) ? 16'h0077 : 16'h0100 + 16'(i))) begin
        errors++; $display("FAIL fullpop_drain index %0d valid %b data %h", i, out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while (rx < 100 && cyc < 400) begin
      in_valid = (tx < 100);
      in_data  = 16'hC000 + 16'(tx);
      if (in_valid && !in_ready) begin
        checks++; errors++; $display("FAIL stream_stall cycle %0d in_ready 0 want 1", cyc);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 16'hC000 + 16'(rx)) begin errors++; $display("FAIL stream_data index %0d got %h want %h", rx, out_data, 16'hC000 + 16'(rx)); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (rx !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", rx); end
    checks++; if (cyc !== 102) begin errors++; $display("FAIL stream_cycles got %0d want 102", cyc); end
  endtask

  task automatic test_random();
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_dat = '0;
    while (rx < 1000 && cyc < 20000) begin
      in_valid  = (tx < 1000) && ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = pat(tx);
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_dat) begin
          errors++; $display("FAIL rand_hold cycle %0d valid %b data %h want 1 %h", cyc, out_valid, out_data, hold_dat);
        end
      end
      checks++;
      if (level !== 5'(tx - rx)) begin errors++; $display("FAIL rand_level cycle %0d got %0d want %0d", cyc, level, tx - rx); end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== pat(rx)) begin errors++; $display("FAIL rand_data index %0d got %h want %h", rx, out_data, pat(rx)); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      hold_prev = out_valid && !out_ready;
      hold_dat  = out_data;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (rx !== 1000) begin errors++; $display("FAIL rand_count got %0d want 1000", rx); end
  endtask

  task automatic test_clear(input logic use_flush);
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_data = 16'h0E00 + 16'(i); in_valid = 1'b1;
      step();
    end
    checks++; if (level !== 5'd9) begin errors++; $display("FAIL clear_pre_level flush=%b got %0d want 9", use_flush, level); end
    in_data = 16'hDEAD; in_valid = 1'b1; out_ready = 1'b1;
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready_during flush=%b got %b want 0", use_flush, in_ready); end
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
      errors++; $display("FAIL clear_state flush=%b level %0d valid %b in_ready %b data %h want 0 0 1 0000", use_flush, level, out_valid, in_ready, out_data);
    end
    in_data = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 5'd1) begin
      errors++; $display("FAIL clear_fresh flush=%b valid %b data %h level %0d want 1 1234 1", use_flush, out_valid, out_data, level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL clear_no_stale flush=%b valid %b level %0d want 0 0", use_flush, out_valid, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_random();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
